// File: rtl/axil_master.sv
// Single-outstanding AXI4-Lite initiator: each accepted command becomes one AXI-Lite read or
// write, and its result is returned on a valid/ready response stream with an optional stall watchdog.
module axil_master #(
    parameter int C_M_AXI_DATA_WIDTH = 32,
    parameter int C_M_AXI_ADDR_WIDTH = 4,
    parameter int TIMEOUT_CYCLES     = 1024
) (
    input  logic                            M_AXI_ACLK,
    input  logic                            M_AXI_ARESET,
    input  logic                            cmd_valid,
    output logic                            cmd_ready,
    input  logic                            cmd_write,
    input  logic [C_M_AXI_ADDR_WIDTH-1:0]   cmd_addr,
    input  logic [C_M_AXI_DATA_WIDTH-1:0]   cmd_wdata,
    input  logic [C_M_AXI_DATA_WIDTH/8-1:0] cmd_wstrb,
    output logic                            rsp_valid,
    input  logic                            rsp_ready,
    output logic                            rsp_write,
    output logic [C_M_AXI_DATA_WIDTH-1:0]   rsp_rdata,
    output logic [1:0]                      rsp_resp,
    output logic                            timeout,
    output logic [C_M_AXI_ADDR_WIDTH-1:0]   M_AXI_AWADDR,
    output logic [2:0]                      M_AXI_AWPROT,
    output logic                            M_AXI_AWVALID,
    input  logic                            M_AXI_AWREADY,
    output logic [C_M_AXI_DATA_WIDTH-1:0]   M_AXI_WDATA,
    output logic [C_M_AXI_DATA_WIDTH/8-1:0] M_AXI_WSTRB,
    output logic                            M_AXI_WVALID,
    input  logic                            M_AXI_WREADY,
    input  logic [1:0]                      M_AXI_BRESP,
    input  logic                            M_AXI_BVALID,
    output logic                            M_AXI_BREADY,
    output logic [C_M_AXI_ADDR_WIDTH-1:0]   M_AXI_ARADDR,
    output logic [2:0]                      M_AXI_ARPROT,
    output logic                            M_AXI_ARVALID,
    input  logic                            M_AXI_ARREADY,
    input  logic [C_M_AXI_DATA_WIDTH-1:0]   M_AXI_RDATA,
    input  logic [1:0]                      M_AXI_RRESP,
    input  logic                            M_AXI_RVALID,
    output logic                            M_AXI_RREADY
);

    localparam int STRB_W = C_M_AXI_DATA_WIDTH / 8;
    localparam int CNT_W  = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;

    typedef enum logic [2:0] {
        IDLE,
        WR_REQ,
        WR_RESP,
        RD_REQ,
        RD_RESP,
        RSP
    } state_e;

    state_e                         state_q, state_d;
    logic [C_M_AXI_ADDR_WIDTH-1:0]  addr_q, addr_d;
    logic [C_M_AXI_DATA_WIDTH-1:0]  wdata_q, wdata_d;
    logic [STRB_W-1:0]              wstrb_q, wstrb_d;
    logic                           write_q, write_d;
    logic [C_M_AXI_DATA_WIDTH-1:0]  rdata_q, rdata_d;
    logic [1:0]                     resp_q, resp_d;
    logic                           awvalid_q, awvalid_d;
    logic                           wvalid_q, wvalid_d;
    logic                           arvalid_q, arvalid_d;
    logic                           bready_q, bready_d;
    logic                           rready_q, rready_d;
    logic                           rsp_valid_q, rsp_valid_d;
    logic [CNT_W-1:0]               cnt_q, cnt_d;

    logic accept;
    logic busy;
    logic aw_fin;
    logic w_fin;

    assign accept = (state_q == IDLE) && cmd_valid;
    assign busy   = state_q inside {WR_REQ, WR_RESP, RD_REQ, RD_RESP};
    // A write channel is finished once its VALID is already down or is handshaking now.
    assign aw_fin = !awvalid_q || M_AXI_AWREADY;
    assign w_fin  = !wvalid_q || M_AXI_WREADY;

    always_ff @(posedge M_AXI_ACLK) begin
        // NOTE: state is updated with non-blocking assignments so every register samples pre-edge values.
        if (M_AXI_ARESET) begin
            state_q     <= IDLE;
            addr_q      <= '0;
            wdata_q     <= '0;
            wstrb_q     <= '0;
            write_q     <= 1'b0;
            rdata_q     <= '0;
            resp_q      <= '0;
            awvalid_q   <= 1'b0;
            wvalid_q    <= 1'b0;
            arvalid_q   <= 1'b0;
            bready_q    <= 1'b0;
            rready_q    <= 1'b0;
            rsp_valid_q <= 1'b0;
            cnt_q       <= '0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            wstrb_q     <= wstrb_d;
            write_q     <= write_d;
            rdata_q     <= rdata_d;
            resp_q      <= resp_d;
            awvalid_q   <= awvalid_d;
            wvalid_q    <= wvalid_d;
            arvalid_q   <= arvalid_d;
            bready_q    <= bready_d;
            rready_q    <= rready_d;
            rsp_valid_q <= rsp_valid_d;
            cnt_q       <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (cmd_valid)          state_d = cmd_write ? WR_REQ : RD_REQ;
            WR_REQ:  if (aw_fin && w_fin)    state_d = WR_RESP;
            WR_RESP: if (M_AXI_BVALID)       state_d = RSP;
            RD_REQ:  if (M_AXI_ARREADY)      state_d = RD_RESP;
            RD_RESP: if (M_AXI_RVALID)       state_d = RSP;
            RSP:     if (rsp_ready)          state_d = IDLE;
            default:                         state_d = IDLE;
        endcase
    end

    always_comb begin
        // NOTE: every next-state value is defaulted first so no branch can infer a latch.
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        wstrb_d     = wstrb_q;
        write_d     = write_q;
        rdata_d     = rdata_q;
        resp_d      = resp_q;
        cnt_d       = cnt_q;
        awvalid_d   = awvalid_q && !M_AXI_AWREADY;
        wvalid_d    = wvalid_q && !M_AXI_WREADY;
        arvalid_d   = arvalid_q && !M_AXI_ARREADY;
        // Ready/valid strobes are the registered decode of the state being entered.
        bready_d    = (state_d == WR_RESP);
        rready_d    = (state_d == RD_RESP);
        rsp_valid_d = (state_d == RSP);

        if (accept) begin
            addr_d    = cmd_addr;
            wdata_d   = cmd_wdata;
            wstrb_d   = cmd_wstrb;
            write_d   = cmd_write;
            awvalid_d = cmd_write;
            wvalid_d  = cmd_write;
            arvalid_d = !cmd_write;
            cnt_d     = '0;
        end else if (busy && (cnt_q != CNT_W'(TIMEOUT_CYCLES))) begin
            cnt_d = cnt_q + 1'b1;
        end

        if ((state_q == WR_RESP) && M_AXI_BVALID) begin
            resp_d  = M_AXI_BRESP;
            rdata_d = '0;
        end
        if ((state_q == RD_RESP) && M_AXI_RVALID) begin
            resp_d  = M_AXI_RRESP;
            rdata_d = M_AXI_RDATA;
        end
    end

    generate
        if (TIMEOUT_CYCLES > 0) begin : g_timeout
            // The counter saturates, so the match value is seen once per transaction.
            assign timeout = busy && (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));
        end else begin : g_no_timeout
            assign timeout = 1'b0;
        end
    endgenerate

    assign cmd_ready     = (state_q == IDLE);
    assign rsp_valid     = rsp_valid_q;
    assign rsp_write     = write_q;
    assign rsp_rdata     = rdata_q;
    assign rsp_resp      = resp_q;
    assign M_AXI_AWADDR  = addr_q;
    assign M_AXI_AWPROT  = 3'b000;
    assign M_AXI_AWVALID = awvalid_q;
    assign M_AXI_WDATA   = wdata_q;
    assign M_AXI_WSTRB   = wstrb_q;
    assign M_AXI_WVALID  = wvalid_q;
    assign M_AXI_BREADY  = bready_q;
    assign M_AXI_ARADDR  = addr_q;
    assign M_AXI_ARPROT  = 3'b000;
    assign M_AXI_ARVALID = arvalid_q;
    assign M_AXI_RREADY  = rready_q;

endmodule

// File: tb/tb_axil_master.sv
// Bench for axil_master: behavioural AXI-Lite slave with programmable stalls and responses,
// plus a word-memory and latency model of the expected command/response behaviour.
`timescale 1ns/1ps
module tb_axil_master;

    localparam int DW = 32;
    localparam int AW = 4;
    localparam int SW = DW / 8;
    localparam int TO = 8;

    logic          clk = 1'b0;
    logic          rst;
    logic          cmd_valid, cmd_ready, cmd_write;
    logic [AW-1:0] cmd_addr;
    logic [DW-1:0] cmd_wdata;
    logic [SW-1:0] cmd_wstrb;
    logic          rsp_valid, rsp_ready, rsp_write;
    logic [DW-1:0] rsp_rdata;
    logic [1:0]    rsp_resp;
    logic          timeout;
    logic [AW-1:0] awaddr, araddr;
    logic [2:0]    awprot, arprot;
    logic          awvalid, awready, wvalid, wready, bvalid, bready;
    logic          arvalid, arready, rvalid, rready;
    logic [DW-1:0] wdata, rdata;
    logic [SW-1:0] wstrb;
    logic [1:0]    bresp, rresp;

    axil_master #(
        .C_M_AXI_DATA_WIDTH(DW),
        .C_M_AXI_ADDR_WIDTH(AW),
        .TIMEOUT_CYCLES    (TO)
    ) dut (
        .M_AXI_ACLK   (clk),
        .M_AXI_ARESET (rst),
        .cmd_valid    (cmd_valid),
        .cmd_ready    (cmd_ready),
        .cmd_write    (cmd_write),
        .cmd_addr     (cmd_addr),
        .cmd_wdata    (cmd_wdata),
        .cmd_wstrb    (cmd_wstrb),
        .rsp_valid    (rsp_valid),
        .rsp_ready    (rsp_ready),
        .rsp_write    (rsp_write),
        .rsp_rdata    (rsp_rdata),
        .rsp_resp     (rsp_resp),
        .timeout      (timeout),
        .M_AXI_AWADDR (awaddr),
        .M_AXI_AWPROT (awprot),
        .M_AXI_AWVALID(awvalid),
        .M_AXI_AWREADY(awready),
        .M_AXI_WDATA  (wdata),
        .M_AXI_WSTRB  (wstrb),
        .M_AXI_WVALID (wvalid),
        .M_AXI_WREADY (wready),
        .M_AXI_BRESP  (bresp),
        .M_AXI_BVALID (bvalid),
        .M_AXI_BREADY (bready),
        .M_AXI_ARADDR (araddr),
        .M_AXI_ARPROT (arprot),
        .M_AXI_ARVALID(arvalid),
        .M_AXI_ARREADY(arready),
        .M_AXI_RDATA  (rdata),
        .M_AXI_RRESP  (rresp),
        .M_AXI_RVALID (rvalid),
        .M_AXI_RREADY (rready)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    endtask

    function automatic logic [31:0] init_word(input int i);
        return (i == 1) ? 32'hDEAD_BEEF : 32'(32'h1111_1111 * (i + 1));
    endfunction

    // Slave configuration, written only by the sequencer.
    int         cfg_aw_d, cfg_w_d, cfg_b_d, cfg_ar_d, cfg_r_d;
    logic [1:0] cfg_bresp, cfg_rresp;
    int         txn_id = 0;

    // Slave observations, written only by the slave process.
    int          aw_hs, w_hs, b_hs, ar_hs, r_hs, viol, to_cnt, to_cyc;
    logic [3:0]  obs_awaddr, obs_araddr, obs_wstrb;
    logic [31:0] obs_wdata;

    // Slave runs 1ns after each falling edge, after the sequencer has driven for that cycle.
    initial begin : slave
        logic [31:0] s_mem [4];
        int   seen_id, aw_wait, w_wait, ar_wait, b_wait, r_wait;
        bit   aw_done, w_done, ar_done, wr_commit, b_pend, r_pend, b_done, r_done;
        bit   aw_stall, w_stall, ar_stall;
        logic [3:0]  p_awaddr, p_araddr;
        logic [31:0] p_wdata;
        for (int i = 0; i < 4; i++) s_mem[i] = init_word(i);
        {awready, wready, bvalid, arready, rvalid} = '0;
        bresp = '0; rresp = '0; rdata = '0;
        to_cnt = 0; to_cyc = 0; seen_id = -1;
        forever begin
            @(negedge clk); #1;
            if (timeout) begin to_cnt++; to_cyc = cyc; end
            if (rst || txn_id != seen_id) begin
                seen_id = txn_id;
                {aw_wait, w_wait, ar_wait, b_wait, r_wait} = '0;
                {aw_done, w_done, ar_done, wr_commit, b_pend, r_pend, b_done, r_done} = '0;
                {aw_stall, w_stall, ar_stall} = '0;
                {aw_hs, w_hs, b_hs, ar_hs, r_hs, viol} = '0;
            end
            if (rst) begin
                {awready, wready, bvalid, arready, rvalid} = '0;
                continue;
            end
            if ((awvalid && aw_done) || (wvalid && w_done) || (arvalid && ar_done)) viol++;
            if (bready && (!(aw_done && w_done) || b_done)) viol++;
            if (rready && (!ar_done || r_done)) viol++;
            if (aw_stall && (!awvalid || awaddr != p_awaddr)) viol++;
            if (w_stall && (!wvalid || wdata != p_wdata)) viol++;
            if (ar_stall && (!arvalid || araddr != p_araddr)) viol++;

            awready = 1'b0;
            if (awvalid && !aw_done) begin
                if (aw_wait >= cfg_aw_d) awready = 1'b1; else aw_wait++;
            end
            wready = 1'b0;
            if (wvalid && !w_done) begin
                if (w_wait >= cfg_w_d) wready = 1'b1; else w_wait++;
            end
            arready = 1'b0;
            if (arvalid && !ar_done) begin
                if (ar_wait >= cfg_ar_d) arready = 1'b1; else ar_wait++;
            end
            bvalid = 1'b0;
            if (b_pend) begin
                if (b_wait >= cfg_b_d) begin bvalid = 1'b1; bresp = cfg_bresp; end
                else b_wait++;
            end
            rvalid = 1'b0;
            if (r_pend) begin
                if (r_wait >= cfg_r_d) begin
                    rvalid = 1'b1; rresp = cfg_rresp; rdata = s_mem[obs_araddr[3:2]];
                end else r_wait++;
            end

            if (awvalid && awready) begin aw_done = 1; aw_hs++; obs_awaddr = awaddr; end
            if (wvalid && wready) begin w_done = 1; w_hs++; obs_wdata = wdata; obs_wstrb = wstrb; end
            if (aw_done && w_done && !wr_commit) begin
                wr_commit = 1; b_pend = 1; b_wait = 0;
                for (int b = 0; b < 4; b++)
                    if (obs_wstrb[b]) s_mem[obs_awaddr[3:2]][8*b +: 8] = obs_wdata[8*b +: 8];
            end
            if (arvalid && arready) begin ar_done = 1; ar_hs++; obs_araddr = araddr; r_pend = 1; r_wait = 0; end
            if (bvalid && bready) begin b_hs++; b_pend = 0; b_done = 1; end
            if (rvalid && rready) begin r_hs++; r_pend = 0; r_done = 1; end

            aw_stall = awvalid && !awready; p_awaddr = awaddr;
            w_stall  = wvalid && !wready;   p_wdata  = wdata;
            ar_stall = arvalid && !arready; p_araddr = araddr;
        end
    end

    logic [31:0] model_mem [4];

    task automatic check_idle(input string tag);
        check({tag, ".awvalid"}, awvalid, 0);
        check({tag, ".wvalid"}, wvalid, 0);
        check({tag, ".arvalid"}, arvalid, 0);
        check({tag, ".bready"}, bready, 0);
        check({tag, ".rready"}, rready, 0);
        check({tag, ".rsp_valid"}, rsp_valid, 0);
        check({tag, ".timeout"}, timeout, 0);
        check({tag, ".cmd_ready"}, cmd_ready, 1);
    endtask

    task automatic run_txn(input bit wr, input logic [3:0] addr, input logic [31:0] wd,
                           input logic [3:0] ws, input int aw_d, input int w_d, input int b_d,
                           input int ar_d, input int r_d, input logic [1:0] resp,
                           input int rr_d, input string tag);
        int acc, rv, waited, to0, lat_exp, exp_to;
        logic [31:0] exp_rdata;
        cfg_aw_d = aw_d; cfg_w_d = w_d; cfg_b_d = b_d; cfg_ar_d = ar_d; cfg_r_d = r_d;
        cfg_bresp = resp; cfg_rresp = resp;
        @(negedge clk);
        txn_id++;
        cmd_valid = 1'b1; cmd_write = wr; cmd_addr = addr; cmd_wdata = wd; cmd_wstrb = ws;
        waited = 0;
        while (!cmd_ready && waited < 50) begin @(negedge clk); waited++; end
        check({tag, ".cmd_ready"}, cmd_ready, 1);
        if (!cmd_ready) begin cmd_valid = 1'b0; return; end
        acc = cyc;
        to0 = to_cnt;
        exp_rdata = wr ? 32'h0 : model_mem[addr[3:2]];
        if (wr) begin
            for (int b = 0; b < 4; b++)
                if (ws[b]) model_mem[addr[3:2]][8*b +: 8] = wd[8*b +: 8];
        end
        lat_exp = wr ? 3 + ((aw_d > w_d) ? aw_d : w_d) + b_d : 3 + ar_d + r_d;

        @(negedge clk);
        cmd_valid = 1'b0;
        waited = 0;
        while (!rsp_valid && waited < 200) begin @(negedge clk); waited++; end
        check({tag, ".rsp_valid"}, rsp_valid, 1);
        if (!rsp_valid) return;
        rv = cyc;
        check({tag, ".latency"}, rv - acc, lat_exp);
        check({tag, ".rdata0"}, rsp_rdata, exp_rdata);
        repeat (rr_d) @(negedge clk);
        rsp_ready = 1'b1;
        check({tag, ".rsp_held"}, rsp_valid, 1);
        check({tag, ".rsp_write"}, rsp_write, wr);
        check({tag, ".rdata"}, rsp_rdata, exp_rdata);
        check({tag, ".resp"}, rsp_resp, resp);
        @(negedge clk);
        rsp_ready = 1'b0;
        check({tag, ".next_cmd_ready"}, cmd_ready, 1);
        check({tag, ".rsp_dropped"}, rsp_valid, 0);
        check({tag, ".proto"}, viol, 0);
        if (wr) begin
            check({tag, ".hs_counts"}, {aw_hs[7:0], w_hs[7:0], b_hs[7:0], ar_hs[7:0]}, 32'h0101_0100);
            check({tag, ".awaddr"}, obs_awaddr, addr);
            check({tag, ".wdata"}, obs_wdata, wd);
            check({tag, ".wstrb"}, obs_wstrb, ws);
        end else begin
            check({tag, ".hs_counts"}, {aw_hs[7:0], w_hs[7:0], ar_hs[7:0], r_hs[7:0]}, 32'h0000_0101);
            check({tag, ".araddr"}, obs_araddr, addr);
        end
        // Busy cycles span acc+1 .. acc+lat_exp-1; the pulse lands at acc+TO if still busy.
        exp_to = (lat_exp - 1 >= TO) ? 1 : 0;
        check({tag, ".timeout_count"}, to_cnt - to0, exp_to);
        if (exp_to == 1) check({tag, ".timeout_cycle"}, to_cyc - acc, TO);
    endtask

    initial begin : sequencer
        int waited;
        bit wr;
        logic [3:0] a, s;
        int rsel;
        for (int i = 0; i < 4; i++) model_mem[i] = init_word(i);
        rst = 1'b1; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0;
        cmd_wdata = '0; cmd_wstrb = '0; rsp_ready = 1'b0;
        repeat (3) @(negedge clk);
        check_idle("reset");
        check("reset.awaddr", awaddr, 0);
        check("reset.wdata", wdata, 0);
        check("reset.prot", {awprot, arprot}, 0);
        rst = 1'b0;

        run_txn(1, 4'h0, 32'h0000_2580, 4'hF, 0, 0, 0, 0, 0, 2'b00, 0, "wr_2580");
        run_txn(0, 4'h0, 32'h0, 4'h0, 0, 0, 0, 0, 0, 2'b00, 0, "rd_2580");
        run_txn(0, 4'h4, 32'h0, 4'h0, 0, 0, 0, 0, 0, 2'b00, 1, "rd_beef");
        run_txn(1, 4'h8, 32'hA5A5_0F0F, 4'hF, 3, 0, 0, 0, 0, 2'b00, 0, "w_before_aw");
        run_txn(1, 4'hC, 32'h1234_5678, 4'hF, 0, 3, 1, 0, 0, 2'b00, 2, "aw_before_w");
        run_txn(1, 4'h8, 32'hFFEE_DDCC, 4'h5, 1, 1, 0, 0, 0, 2'b00, 0, "partial_wr");
        run_txn(0, 4'h8, 32'h0, 4'h0, 0, 0, 0, 0, 1, 2'b00, 0, "partial_rd");
        run_txn(0, 4'hC, 32'h0, 4'h0, 0, 0, 0, 0, 0, 2'b10, 0, "rd_slverr");
        run_txn(1, 4'h4, 32'h0BAD_F00D, 4'hF, 0, 0, 0, 0, 0, 2'b11, 0, "wr_decerr");
        run_txn(0, 4'h0, 32'h0, 4'h0, 0, 0, 0, 20, 0, 2'b00, 0, "timeout_ar20");
        run_txn(0, 4'h4, 32'h0, 4'h0, 0, 0, 0, 5, 0, 2'b00, 0, "timeout_edge_no");
        run_txn(0, 4'h4, 32'h0, 4'h0, 0, 0, 0, 6, 0, 2'b00, 0, "timeout_edge_yes");

        // Reset while the write waits for its B response and the consumer holds rsp_ready low.
        cfg_aw_d = 0; cfg_w_d = 0; cfg_b_d = 30; cfg_bresp = 2'b00;
        @(negedge clk);
        txn_id++;
        cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 4'hC; cmd_wdata = 32'hCAFE_0001; cmd_wstrb = 4'hF;
        @(negedge clk);
        cmd_valid = 1'b0;
        model_mem[3] = 32'hCAFE_0001;
        waited = 0;
        while (!bready && waited < 20) begin @(negedge clk); waited++; end
        check("rst_mid.bready", bready, 1);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check_idle("rst_mid");
        run_txn(0, 4'hC, 32'h0, 4'h0, 0, 0, 0, 1, 1, 2'b00, 0, "rd_after_rst");

        for (int n = 0; n < 40; n++) begin
            wr   = 1'($urandom_range(0, 1));
            a    = {2'($urandom_range(0, 3)), 2'b00};
            s    = 4'($urandom_range(1, 15));
            rsel = $urandom_range(0, 7);
            run_txn(wr, a, $urandom, s, $urandom_range(0, 4), $urandom_range(0, 4),
                    $urandom_range(0, 3), $urandom_range(0, 4), $urandom_range(0, 3),
                    (rsel < 5) ? 2'b00 : 2'(rsel - 4), $urandom_range(0, 3), "rand");
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
